// File: rtl/zoom_controller.sv
// zoom_controller: command FSM that runs one scaling engine, tracks the signed zoom step and flips the ping-pong buffer; RUN watchdog only when ZOOM_CTRL_TIMEOUT_EN is defined.
// Latency: accept edge to done pulse is 2 cycles for NOP/reset-zoom; engine ops add their RUN cycles (at least 2).
// Backpressure: cmd_ready is high only in IDLE, so no further command is taken until the current one has committed or failed.
module zoom_controller #(
  parameter int MAX_LEVEL      = 2,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  output logic              cmd_ready,
  output logic              eng_enable,
  output logic [1:0]        eng_sel,
  input  logic              eng_done,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic signed [2:0] zoom_level,
  output logic              buf_sel
);

  typedef enum logic [2:0] {IDLE, CHECK, RUN, COMMIT, FAIL} state_t;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_IN_REP   = 3'd1;
  localparam logic [2:0] OP_IN_NEAR  = 3'd2;
  localparam logic [2:0] OP_OUT_DEC  = 3'd3;
  localparam logic [2:0] OP_OUT_AVG  = 3'd4;
  localparam logic [2:0] OP_RESET    = 3'd5;

  localparam logic signed [2:0] ZMAX = 3'(MAX_LEVEL);
  localparam logic signed [2:0] ZMIN = 3'(-MAX_LEVEL);

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic              ready_q;
  logic              en_q;
  logic [1:0]        sel_q;
  logic              done_q;
  logic              err_q;
  logic signed [2:0] zoom_q;
  logic              buf_q;
  logic              first_q;   // first RUN cycle: eng_done may still be a stale level

  logic accept;
  logic op_is_in;
  logic op_is_out;
  logic op_illegal;

  assign accept     = cmd_valid && ready_q;
  assign op_is_in   = (op_q == OP_IN_REP)  || (op_q == OP_IN_NEAR);
  assign op_is_out  = (op_q == OP_OUT_DEC) || (op_q == OP_OUT_AVG);
  assign op_illegal = (op_q > OP_RESET);

`ifdef ZOOM_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wd_q;

  // Watchdog: counts RUN cycles, restarting from zero on every RUN entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q <= '0;
    end else if (state_d == RUN && state_q != RUN) begin
      wd_q <= '0;
    end else if (state_q == RUN) begin
      wd_q <= wd_q + 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  // Next-state logic: legality check, engine wait, commit/fail back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = CHECK;
      CHECK: begin
        if (op_illegal || (op_is_in && zoom_q == ZMAX) || (op_is_out && zoom_q == ZMIN)) begin
          state_d = FAIL;
        end else if (op_q == OP_NOP || op_q == OP_RESET) begin
          state_d = COMMIT;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!first_q && eng_done) begin
          state_d = COMMIT;
`ifdef ZOOM_CTRL_TIMEOUT_EN
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = FAIL;
`endif
        end
      end
      COMMIT: state_d = IDLE;
      FAIL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; zoom/buffer/done/error update on the edge leaving COMMIT or FAIL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      sel_q   <= 2'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      zoom_q  <= 3'sd0;
      buf_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      en_q    <= (state_d == RUN);
      first_q <= (state_d == RUN) && (state_q != RUN);
      done_q  <= (state_q == COMMIT);
      if (accept) begin
        op_q  <= cmd_op;
        err_q <= 1'b0;
        sel_q <= (cmd_op >= OP_IN_REP && cmd_op <= OP_OUT_AVG) ? 2'(cmd_op - 3'd1) : 2'd0;
      end else if (state_q == FAIL) begin
        err_q <= 1'b1;
      end
      if (state_q == COMMIT) begin
        if (op_is_in) begin
          zoom_q <= zoom_q + 3'sd1;
          buf_q  <= ~buf_q;
        end else if (op_is_out) begin
          zoom_q <= zoom_q - 3'sd1;
          buf_q  <= ~buf_q;
        end else if (op_q == OP_RESET) begin
          zoom_q <= 3'sd0;
        end
      end
    end
  end

  assign cmd_ready  = ready_q;
  assign eng_enable = en_q;
  assign eng_sel    = sel_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign error      = err_q;
  assign zoom_level = zoom_q;
  assign buf_sel    = buf_q;

endmodule

// File: tb/tb_zoom_controller.sv
// tb_zoom_controller: directed and randomized command sequences against a transaction-level zoom model.
// Each command is observed cycle by cycle (engine enable time, done position, ready return, final state).
// The engine is emulated in the bench: it raises eng_done after a chosen number of enabled cycles.
module tb_zoom_controller;

  localparam int MAXL = 2;
`ifdef ZOOM_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  localparam int TO    = 16;
`else
  localparam bit TO_EN = 1'b0;
  localparam int TO    = 131072;
`endif

  logic              clk;
  logic              reset_n;
  logic              cmd_valid;
  logic [2:0]        cmd_op;
  logic              cmd_ready;
  logic              eng_enable;
  logic [1:0]        eng_sel;
  logic              eng_done;
  logic              busy;
  logic              done;
  logic              error;
  logic signed [2:0] zoom_level;
  logic              buf_sel;

  zoom_controller #(.MAX_LEVEL(MAXL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .eng_enable(eng_enable), .eng_sel(eng_sel),
    .eng_done(eng_done), .busy(busy), .done(done), .error(error),
    .zoom_level(zoom_level), .buf_sel(buf_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int en;        // cycles eng_enable was high
    int ready_k;   // cycles after accept edge until cmd_ready returns
    int done_k;    // cycles after accept edge of the first done pulse (-1 none)
    int done_n;    // number of cycles done was high
    int zoom;
    bit sel_bad;
    bit err;
    bit bufs;
    bit busy0;
    bit rdy0;
    bit err0;
  } obs_t;

  int n_chk;
  int n_pass;
  int zoom_m;
  bit buf_m;
  bit err_m;

  function automatic string fmt(obs_t o);
    return $sformatf("en=%0d rdy=%0d dk=%0d dn=%0d z=%0d buf=%0b err=%0b selbad=%0b b0=%0b r0=%0b e0=%0b",
                     o.en, o.ready_k, o.done_k, o.done_n, o.zoom, o.bufs, o.err, o.sel_bad,
                     o.busy0, o.rdy0, o.err0);
  endfunction

  // Transaction-level model: what a command should do, given the current zoom state.
  function automatic obs_t predict(int op, int lat);
    obs_t e;
    bit   illegal;
    int   run;
    e = '0;
    e.done_k = -1;
    e.busy0  = 1'b1;
    illegal = (op >= 6) || ((op == 1 || op == 2) && zoom_m == MAXL) ||
              ((op == 3 || op == 4) && zoom_m == -MAXL);
    if (illegal) begin
      e.ready_k = 2;
      e.err     = 1'b1;
    end else if (op == 0 || op == 5) begin
      e.ready_k = 2;
      e.done_k  = 2;
      e.done_n  = 1;
      if (op == 5) zoom_m = 0;
    end else begin
      run = (lat < 2) ? 2 : lat;
      if (TO_EN && run > TO) begin
        e.en      = TO;
        e.ready_k = TO + 2;
        e.err     = 1'b1;
      end else begin
        e.en      = run;
        e.ready_k = run + 2;
        e.done_k  = run + 2;
        e.done_n  = 1;
        zoom_m    = zoom_m + ((op <= 2) ? 1 : -1);
        buf_m     = ~buf_m;
      end
    end
    err_m  = e.err;
    e.zoom = zoom_m;
    e.bufs = buf_m;
    return e;
  endfunction

  // Issue one command, emulate the engine, and record what the DUT did.
  task automatic run_op(input int op, input int lat, output obs_t o);
    int en_cnt;
    int budget;
    o = '0;
    o.ready_k = -1;
    o.done_k  = -1;
    for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) @(negedge clk);
    if (cmd_ready !== 1'b1) begin
      o.ready_k = -2;
      return;
    end
    eng_done  = (lat == 0);   // stale-high level at RUN entry must be ignored
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom_range(0, 7));
    o.busy0 = busy;
    o.rdy0  = cmd_ready;
    o.err0  = error;
    en_cnt  = 0;
    budget  = lat + 40;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (eng_enable === 1'b1) begin
        en_cnt++;
        if (eng_sel !== 2'(op - 1)) o.sel_bad = 1'b1;
        if (en_cnt >= lat) eng_done = 1'b1;
      end else if (en_cnt > 0) begin
        eng_done = 1'b0;
      end
      if (done === 1'b1) begin
        o.done_n++;
        if (o.done_k < 0) o.done_k = k;
      end
      if (cmd_ready === 1'b1) begin
        o.ready_k = k;
        break;
      end
    end
    @(negedge clk);
    if (done === 1'b1) o.done_n++;
    eng_done = 1'b0;
    o.en   = en_cnt;
    o.err  = error;
    o.zoom = $signed(zoom_level);
    o.bufs = buf_sel;
  endtask

  task automatic test_reset();
    #3;
    n_chk++;
    if ({cmd_ready, busy, eng_enable, eng_sel, done, error, zoom_level, buf_sel} !== 11'b0)
      $display("FAIL reset_outputs: got %b want 0", {cmd_ready, busy, eng_enable, eng_sel, done, error, zoom_level, buf_sel});
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_chk++;
    if (cmd_ready !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", cmd_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    n_chk++;
    if (cmd_ready !== 1'b1) $display("FAIL ready_after_release: got %b want 1", cmd_ready);
    else n_pass++;
  endtask

  task automatic test_zoom_in_replicate();
    obs_t e, o;
    e = predict(1, 76800);
    run_op(1, 76800, o);
    n_chk++;
    if (o !== e) $display("FAIL zoom_in_replicate: got %s want %s", fmt(o), fmt(e));
    else n_pass++;
  endtask

  task automatic test_limit();
    obs_t e, o;
    int lat;
    lat = $urandom_range(2, 10);
    e = predict(1, lat);
    run_op(1, lat, o);
    n_chk++;
    if (o !== e) $display("FAIL zoom_in_to_max: got %s want %s", fmt(o), fmt(e));
    else n_pass++;
    e = predict(2, 5);
    run_op(2, 5, o);
    n_chk++;
    if (o !== e) $display("FAIL zoom_in_at_max: got %s want %s", fmt(o), fmt(e));
    else n_pass++;
  endtask

  task automatic test_illegal_then_nop();
    obs_t e, o;
    e = predict(7, 3);
    run_op(7, 3, o);
    n_chk++;
    if (o !== e) $display("FAIL illegal_op7: got %s want %s", fmt(o), fmt(e));
    else n_pass++;
    e = predict(0, 3);
    run_op(0, 3, o);
    n_chk++;
    if (o !== e) $display("FAIL nop_after_error: got %s want %s", fmt(o), fmt(e));
    else n_pass++;
  endtask

  task automatic test_reset_zoom();
    obs_t e, o;
    int op;
    for (int i = 0; i < 8 && zoom_m != -1; i++) begin
      op = (zoom_m > -1) ? 3 : 1;
      e = predict(op, 4);
      run_op(op, 4, o);
      n_chk++;
      if (o !== e) $display("FAIL walk_to_minus1 op%0d: got %s want %s", op, fmt(o), fmt(e));
      else n_pass++;
    end
    e = predict(5, 0);
    run_op(5, 0, o);
    n_chk++;
    if (o !== e) $display("FAIL reset_zoom: got %s want %s", fmt(o), fmt(e));
    else n_pass++;
  endtask

  task automatic test_random();
    obs_t e, o;
    int op;
    int lat;
    for (int i = 0; i < 40; i++) begin
      op  = $urandom_range(0, 7);
      lat = $urandom_range(0, 24);
      e = predict(op, lat);
      run_op(op, lat, o);
      n_chk++;
      if (o !== e) $display("FAIL random[%0d] op%0d lat%0d: got %s want %s", i, op, lat, fmt(o), fmt(e));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_run();
    obs_t e, o;
    int op;
    bit seen;
    op = (zoom_m < MAXL) ? 1 : 3;
    for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (eng_enable === 1'b1) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b1) $display("FAIL run_before_reset: eng_enable got %b want 1", seen);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if ({cmd_ready, busy, eng_enable, eng_sel, done, error, zoom_level, buf_sel} !== 11'b0)
      $display("FAIL async_reset_mid_run: got %b want 0", {cmd_ready, busy, eng_enable, eng_sel, done, error, zoom_level, buf_sel});
    else n_pass++;
    zoom_m = 0;
    buf_m  = 1'b0;
    err_m  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({cmd_ready, busy, eng_enable, done} !== 4'b0)
      $display("FAIL held_in_reset: got %b want 0000", {cmd_ready, busy, eng_enable, done});
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_chk++;
    if (cmd_ready !== 1'b0) $display("FAIL ready_at_release: got %b want 0", cmd_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    n_chk++;
    if (cmd_ready !== 1'b1) $display("FAIL ready_one_cycle_after_release: got %b want 1", cmd_ready);
    else n_pass++;
    e = predict(0, 1);
    run_op(0, 1, o);
    n_chk++;
    if (o !== e) $display("FAIL nop_after_reset: got %s want %s", fmt(o), fmt(e));
    else n_pass++;
  endtask

`ifdef ZOOM_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    obs_t e, o;
    int op;
    op = (zoom_m < MAXL) ? 2 : 4;
    e = predict(op, 1000);
    run_op(op, 1000, o);
    n_chk++;
    if (o !== e) $display("FAIL watchdog_timeout: got %s want %s", fmt(o), fmt(e));
    else n_pass++;
    n_chk++;
    if (eng_enable !== 1'b0) $display("FAIL enable_after_timeout: got %b want 0", eng_enable);
    else n_pass++;
  endtask
`endif

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    zoom_m    = 0;
    buf_m     = 1'b0;
    err_m     = 1'b0;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    eng_done  = 1'b0;
    test_reset();
    test_zoom_in_replicate();
    test_limit();
    test_illegal_then_nop();
    test_reset_zoom();
    test_random();
    test_reset_mid_run();
`ifdef ZOOM_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: run did not complete, %0d/%0d passed so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/zoom_controller.md
ZOOM_CONTROLLER -- requirements
Module: zoom_controller

Interface
REQ-001 SHALL have parameter MAX_LEVEL, default 2: maximum zoom-in and zoom-out steps from 1:1.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 131072: engine watchdog limit in clk cycles.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1: command request.
REQ-006 SHALL have port cmd_op, input, 3: 0 NOP, 1 zoom-in replicate, 2 zoom-in nearest, 3 zoom-out decimate, 4 zoom-out average, 5 reset-zoom, 6-7 illegal.
REQ-007 SHALL have port cmd_ready, output, 1: command accepted on the clk edge where cmd_valid and cmd_ready are both high.
REQ-008 SHALL have port eng_enable, output, 1: enable to the selected scaling engine; low holds its address pointer at 0.
REQ-009 SHALL have port eng_sel, output, 2: engine select, 0 replicate, 1 nearest, 2 decimate, 3 average.
REQ-010 SHALL have port eng_done, input, 1: engine-complete level from the selected engine.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1: one-cycle pulse on successful command completion.
REQ-013 SHALL have port error, output, 1: sticky failure flag.
REQ-014 SHALL have port zoom_level, output, 3: signed two's-complement zoom step, range -MAX_LEVEL..+MAX_LEVEL.
REQ-015 SHALL have port buf_sel, output, 1: ping-pong framebuffer select; the engine reads buffer buf_sel and writes buffer ~buf_sel.

Function
REQ-016 SHALL implement states IDLE, CHECK, RUN, COMMIT, FAIL.
REQ-017 SHALL assert cmd_ready only in IDLE.
REQ-018 SHALL move IDLE->CHECK on accept, latch cmd_op, and clear error in the same edge.
REQ-019 SHALL move CHECK->FAIL for op 6-7, for ops 1-2 with zoom_level==+MAX_LEVEL, and for ops 3-4 with zoom_level==-MAX_LEVEL.
REQ-020 SHALL move CHECK->COMMIT for ops 0 and 5 without asserting eng_enable.
REQ-021 SHALL move CHECK->RUN for legal ops 1-4 and drive eng_sel=op-1 from CHECK through COMMIT.
REQ-022 SHALL drive eng_enable registered, high exactly while in RUN.
REQ-023 SHALL ignore eng_done in the first RUN cycle and move RUN->COMMIT on the first later cycle with eng_done=1.
REQ-024 SHALL, in COMMIT, pulse done for one cycle and apply: ops 1-2 zoom_level+1 and toggle buf_sel; ops 3-4 zoom_level-1 and toggle buf_sel; op 5 zoom_level=0 with buf_sel unchanged; op 0 no change; then return to IDLE.
REQ-025 SHALL, in FAIL, set error=1, leave zoom_level and buf_sel unchanged, not pulse done, and return to IDLE after one cycle.
REQ-026 SHALL keep error high until the next accepted command.
REQ-027 SHALL change zoom_level only in COMMIT, so it never leaves range.
REQ-028 SHALL give a latency from accept edge to done pulse of 2 cycles for ops 0 and 5.

Reset
REQ-029 SHALL, while reset_n=0, immediately force state IDLE, cmd_ready=0, eng_enable=0, eng_sel=0, busy=0, done=0, error=0, zoom_level=0, buf_sel=0, and the watchdog counter to 0.
REQ-030 SHALL, on reset mid-RUN, abort the engine (eng_enable low) without commit, and assert cmd_ready one cycle after reset_n rises.

Configuration
REQ-031 SHALL, with macro ZOOM_CTRL_TIMEOUT_EN defined, count RUN cycles and move RUN->FAIL when the count reaches TIMEOUT_CYCLES without eng_done, zeroing the counter on RUN entry.
REQ-032 SHALL, without ZOOM_CTRL_TIMEOUT_EN, contain no watchdog counter and wait in RUN indefinitely for eng_done.

Verification
REQ-033 SHALL test: after reset, op 1 with engine done after 76800 cycles -> eng_sel=0, eng_enable high 76800+ cycles, one done pulse, zoom_level=1, buf_sel=1.
REQ-034 SHALL test: at zoom_level=+2, op 2 -> no eng_enable, error=1, zoom_level stays 2, no done pulse.
REQ-035 SHALL test: op 7 -> error=1; then op 0 -> error cleared and done pulses 2 cycles after accept.
REQ-036 SHALL test: at zoom_level=-1, buf_sel=1, op 5 -> zoom_level=0, buf_sel=1, done pulses 2 cycles after accept.
REQ-037 SHALL test: reset_n low during RUN -> all outputs to reset values asynchronously, zoom_level=0, and cmd_ready=1 one cycle after release.
REQ-038 SHALL test with ZOOM_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16, eng_done held 0 -> FAIL after 16 RUN cycles, error=1, eng_enable low.
